pool2d_stream: RTL

POOL2D_STREAM -- requirements
Module: pool2d_stream

---
 rtl/pool_pkg.sv | 22 ++
 rtl/pool_pair_reduce.sv | 31 +++
 rtl/pool2d_stream.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 stride-2 pooling stream.
// No logic of its own; zero latency.
// No flow control; imported by pool2d_stream and pool_pair_reduce.
package pool_pkg;

    // Frame sequencing: rows alternate even/odd, then wait for the last output.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVEN_ROW = 2'd1,
        ST_ODD_ROW  = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_AVG = 1'b1;

    // Horizontal partials need one guard bit so an average-mode pair sum cannot overflow.
    function automatic int partial_w(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/pool_pair_reduce.sv
// Combinational two-input reduction: signed max or signed sum, selected by mode.
// Zero latency.
// No flow control; the caller qualifies inputs and outputs.
module pool_pair_reduce
    import pool_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 9
)(
    input  logic [IN_W-1:0]  a_i,
    input  logic [IN_W-1:0]  b_i,
    input  logic             mode_i,
    output logic [OUT_W-1:0] y_o
);

    logic signed [OUT_W-1:0] a_x;
    logic signed [OUT_W-1:0] b_x;

    assign a_x = {{(OUT_W-IN_W){a_i[IN_W-1]}}, a_i};
    assign b_x = {{(OUT_W-IN_W){b_i[IN_W-1]}}, b_i};

    // Average mode sums the pair; max mode keeps the larger signed value.
    always_comb begin
        if (mode_i == MODE_AVG) begin
            y_o = a_x + b_x;
        end else begin
            y_o = (a_x > b_x) ? a_x : b_x;
        end
    end

endmodule

// File: rtl/pool2d_stream.sv
// 2x2 stride-2 max/average pooling over a streamed single-channel frame.
// Output valid one cycle after the completing odd-row beat is accepted.
// Single-entry output register; input stalls on odd beats only while that register is full and not draining.
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LANES      = 4,
    parameter int MAX_WBEATS = 64
)(
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [$clog2(MAX_WBEATS):0] cfg_wbeats,
    input  logic [15:0]                 cfg_height,
    input  logic                        cfg_mode,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [31:0]                 cycle_cnt,
    input  logic [LANES*DATA_W-1:0]     S_AXIS_TDATA,
    input  logic                        S_AXIS_TVALID,
    output logic                        S_AXIS_TREADY,
    input  logic                        S_AXIS_TLAST,
    output logic [LANES*DATA_W-1:0]     M_AXIS_TDATA,
    output logic                        M_AXIS_TVALID,
    input  logic                        M_AXIS_TREADY,
    output logic                        M_AXIS_TLAST
);

    localparam int HALF = LANES / 2;
    localparam int PW   = partial_w(DATA_W);
    localparam int VW   = DATA_W + 2;
    localparam int AW   = $clog2(MAX_WBEATS);
    localparam int BW   = AW + 1;

    state_t                  state_q, state_d;
    logic [BW-1:0]           wbeats_q, beat_q;
    logic [15:0]             height_q, rowp_q;
    logic                    mode_q, err_q;
    logic [31:0]             cnt_q;
    logic [HALF*DATA_W-1:0]  half_q;
    logic                    out_vld_q, out_last_q;
    logic [LANES*DATA_W-1:0] out_dat_q;
    logic [HALF*PW-1:0]      lb_q [MAX_WBEATS];

    logic [HALF*PW-1:0]      lb_rd, hpart_all;
    logic [HALF*DATA_W-1:0]  res_all;
    logic                    start_ok, in_fire, m_fire, row_end, last_pair, frame_last;

    assign start_ok   = start && (state_q == ST_IDLE);
    assign in_fire    = S_AXIS_TVALID && S_AXIS_TREADY;
    assign m_fire     = out_vld_q && M_AXIS_TREADY;
    assign row_end    = (beat_q == wbeats_q - BW'(1));
    assign last_pair  = (rowp_q == (height_q >> 1) - 16'd1);
    assign frame_last = (state_q == ST_ODD_ROW) && row_end && last_pair;
    assign lb_rd      = lb_q[beat_q[AW-1:0]];

    // Per output lane: horizontal pair reduce, then vertical combine with the stored partial.
    for (genvar k = 0; k < HALF; k++) begin : g_lane
        logic [PW-1:0]        hp;
        logic signed [VW-1:0] vsum, rnd;

        pool_pair_reduce #(.IN_W(DATA_W), .OUT_W(PW)) u_h (
            .a_i    (S_AXIS_TDATA[(2*k)*DATA_W +: DATA_W]),
            .b_i    (S_AXIS_TDATA[(2*k+1)*DATA_W +: DATA_W]),
            .mode_i (mode_q),
            .y_o    (hp)
        );

        pool_pair_reduce #(.IN_W(PW), .OUT_W(VW)) u_v (
            .a_i    (lb_rd[k*PW +: PW]),
            .b_i    (hp),
            .mode_i (mode_q),
            .y_o    (vsum)
        );

        // Round-half-up average: add 2 before the arithmetic divide by 4.
        assign rnd = vsum + VW'(2);
        assign hpart_all[k*PW +: PW]       = hp;
        assign res_all[k*DATA_W +: DATA_W] = (mode_q == MODE_AVG) ? DATA_W'(rnd >>> 2)
                                                                  : vsum[DATA_W-1:0];
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: rows advance on the last accepted beat, drain ends on the final output handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_EVEN_ROW;
            ST_EVEN_ROW: if (in_fire && row_end) state_d = ST_ODD_ROW;
            ST_ODD_ROW:  if (in_fire && row_end) state_d = last_pair ? ST_DRAIN : ST_EVEN_ROW;
            ST_DRAIN:    if (m_fire) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Status and input-ready decode; odd beats that finish an output need a free output slot.
    always_comb begin
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DRAIN) && m_fire;
        S_AXIS_TREADY = 1'b0;
        case (state_q)
            ST_EVEN_ROW: S_AXIS_TREADY = 1'b1;
            ST_ODD_ROW:  S_AXIS_TREADY = !beat_q[0] || !out_vld_q || M_AXIS_TREADY;
            default:     S_AXIS_TREADY = 1'b0;
        endcase
    end

    // Frame bookkeeping, pair holding register and single-entry output register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wbeats_q   <= '0;
            height_q   <= '0;
            mode_q     <= MODE_MAX;
            beat_q     <= '0;
            rowp_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            half_q     <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_dat_q  <= '0;
        end else begin
            if (start_ok) begin
                wbeats_q <= cfg_wbeats;
                height_q <= cfg_height;
                mode_q   <= cfg_mode;
                beat_q   <= '0;
                rowp_q   <= '0;
                cnt_q    <= '0;
                err_q    <= 1'b0;
            end else if (busy) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (in_fire) begin
                if (S_AXIS_TLAST != frame_last) err_q <= 1'b1;
                beat_q <= row_end ? '0 : beat_q + BW'(1);
                if ((state_q == ST_ODD_ROW) && row_end) rowp_q <= rowp_q + 16'd1;
                if ((state_q == ST_ODD_ROW) && !beat_q[0]) half_q <= res_all;
            end
            if (in_fire && (state_q == ST_ODD_ROW) && beat_q[0]) begin
                out_vld_q  <= 1'b1;
                out_dat_q  <= {res_all, half_q};
                out_last_q <= frame_last;
            end else if (m_fire) begin
                out_vld_q  <= 1'b0;
                out_last_q <= 1'b0;
            end
        end
    end

    // Line buffer of even-row partials; contents need no reset.
    always_ff @(posedge CLK) begin
        if (in_fire && (state_q == ST_EVEN_ROW)) lb_q[beat_q[AW-1:0]] <= hpart_all;
    end

    assign err           = err_q;
    assign cycle_cnt     = cnt_q;
    assign M_AXIS_TDATA  = out_dat_q;
    assign M_AXIS_TVALID = out_vld_q;
    assign M_AXIS_TLAST  = out_last_q;

endmodule
